// File: rtl/if_pc_gen_pkg.sv
// Shared types and constants for the fetch-side PC generator.
package rv_if_pkg;

    localparam int PC_W = 30;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 30'h0000_0000;
    localparam logic [PC_W-1:0] PC_INC       = 30'd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pc_state_t;

endpackage

// File: rtl/if_pc_gen_if.sv
// Control and fetch-address bundle between CPU status/EX logic and the PC generator.
interface if_pc_gen_if;
    import rv_if_pkg::*;

    logic            pc_start;
    logic [PC_W-1:0] start_adr_lat;
    logic            stall;
    logic            rst_pipe;
    logic            jmp_condition_ex;
    logic [PC_W-1:0] jmp_adr_ex;
    logic [PC_W-1:0] if_adr;
    logic            if_valid;
    logic [PC_W-1:0] pc_id;
    logic            pc_valid_if_id;
    logic            jmp_flush;
    logic [31:0]     fetch_cnt;

    modport master (
        output pc_start, start_adr_lat, stall, rst_pipe, jmp_condition_ex, jmp_adr_ex,
        input  if_adr, if_valid, pc_id, pc_valid_if_id, jmp_flush, fetch_cnt
    );

    modport slave (
        input  pc_start, start_adr_lat, stall, rst_pipe, jmp_condition_ex, jmp_adr_ex,
        output if_adr, if_valid, pc_id, pc_valid_if_id, jmp_flush, fetch_cnt
    );

endinterface

// File: rtl/if_pc_gen_redirect_buf.sv
// One-entry holding register for a jump target that arrived while the pipe was stalled.
module if_redirect_buf
    import rv_if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [PC_W-1:0] target,
    input  logic            consume,
    input  logic            clear,
    output logic            pend_valid,
    output logic [PC_W-1:0] pend_adr
);

    // Clear/consume beat capture; a newer capture overwrites an older one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_adr   <= '0;
        end else if (clear || consume) begin
            pend_valid <= 1'b0;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_adr   <= target;
        end
    end

endmodule

// File: rtl/if_pc_gen.sv
// Fetch PC generator: start/pipe-reset/stall/redirect sequencing for the IF stage.
// Optional advanced-fetch counter is built when IF_FETCH_CNT_EN is defined.
//
// state | meaning
// IDLE  | no fetch issued, if_valid low, jumps and stall ignored
// RUN   | fetching; if_adr advances, redirects or holds under stall
module if_pc_gen
    import rv_if_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
)
(
    input  logic    clk,
    input  logic    rst,
    if_pc_gen_if.slave bus
);

    localparam logic [0:0] S_IDLE = IDLE;
    localparam logic [0:0] S_RUN  = RUN;

    logic [0:0]      state;
    logic [PC_W-1:0] if_adr_q;
    logic [PC_W-1:0] pc_id_q;
    logic            pc_valid_q;
    logic            jmp_flush_q;

    logic            running;
    logic            hold_ctrl;
    logic            redirect;
    logic            capture;
    logic            seq_adv;
    logic            clear_pend;
    logic            pend_valid;
    logic [PC_W-1:0] pend_adr;
    logic [PC_W-1:0] redir_adr;

    always_comb begin
        running    = (state == S_RUN);
        hold_ctrl  = bus.pc_start || bus.rst_pipe;
        clear_pend = bus.pc_start || (running && bus.rst_pipe);
        redirect   = running && !hold_ctrl && !bus.stall && (bus.jmp_condition_ex || pend_valid);
        capture    = running && !hold_ctrl && bus.stall && bus.jmp_condition_ex;
        seq_adv    = running && !hold_ctrl && !bus.stall && !redirect;
        // A live EX jump is younger than anything pending, so it takes precedence.
        redir_adr  = bus.jmp_condition_ex ? bus.jmp_adr_ex : pend_adr;
    end

    if_redirect_buf u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .target     (bus.jmp_adr_ex),
        .consume    (redirect),
        .clear      (clear_pend),
        .pend_valid (pend_valid),
        .pend_adr   (pend_adr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            if_adr_q    <= RESET_PC;
            pc_id_q     <= '0;
            pc_valid_q  <= 1'b0;
            jmp_flush_q <= 1'b0;
        end else begin
            jmp_flush_q <= 1'b0;
            if (bus.pc_start) begin
                state      <= S_RUN;
                if_adr_q   <= bus.start_adr_lat;
                pc_valid_q <= 1'b0;
            end else if (running && bus.rst_pipe) begin
                state      <= S_IDLE;
                pc_valid_q <= 1'b0;
            end else if (redirect) begin
                if_adr_q    <= redir_adr;
                pc_valid_q  <= 1'b0;
                jmp_flush_q <= 1'b1;
            end else if (seq_adv) begin
                pc_id_q    <= if_adr_q;
                pc_valid_q <= 1'b1;
                if_adr_q   <= if_adr_q + PC_INC;
            end
        end
    end

    assign bus.if_adr         = if_adr_q;
    assign bus.if_valid       = running;
    assign bus.pc_id          = pc_id_q;
    assign bus.pc_valid_if_id = pc_valid_q;
    assign bus.jmp_flush      = jmp_flush_q;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.pc_start) begin
            fetch_cnt_q <= 32'h0;
        end else if (redirect || seq_adv) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
`else
    assign bus.fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: directed vector table plus randomized run against a reference model.
module tb_if_pc_gen;

    logic clk = 1'b0;
    logic rst;

    if_pc_gen_if pcif ();

    if_pc_gen #(.RESET_PC(30'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pcif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        rst;
        bit        ps;
        bit [29:0] sa;
        bit        st;
        bit        rp;
        bit        j;
        bit [29:0] ja;
        bit [29:0] e_adr;
        bit        e_v;
        bit [29:0] e_id;
        bit        e_vid;
        bit        e_fl;
        bit [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit ps, bit [29:0] sa, bit st, bit rp, bit j, bit [29:0] ja,
                                bit [29:0] ea, bit ev, bit [29:0] eid, bit evid, bit efl, bit [31:0] ec);
        vec_t v;
        v.rst = r; v.ps = ps; v.sa = sa; v.st = st; v.rp = rp; v.j = j; v.ja = ja;
        v.e_adr = ea; v.e_v = ev; v.e_id = eid; v.e_vid = evid; v.e_fl = efl; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit ps, bit [29:0] sa, bit st, bit rp, bit j, bit [29:0] ja);
        rst                   = r;
        pcif.pc_start         = ps;
        pcif.start_adr_lat    = sa;
        pcif.stall            = st;
        pcif.rst_pipe         = rp;
        pcif.jmp_condition_ex = j;
        pcif.jmp_adr_ex       = ja;
    endtask

    function automatic bit [31:0] cnt_exp(bit [31:0] c);
`ifdef IF_FETCH_CNT_EN
        return c;
`else
        return 32'h0;
`endif
    endfunction

    // Reference model: pending redirects are kept as a queue holding at most the latest target.
    bit        m_run;
    bit [29:0] m_adr;
    bit [29:0] m_id;
    bit        m_vid;
    bit        m_fl;
    bit [31:0] m_cnt;
    bit [29:0] m_pend[$];

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_adr = 30'h0; m_id = 30'h0; m_vid = 0; m_fl = 0; m_cnt = 0;
            m_pend.delete();
            return;
        end
        m_fl = 0;
        if (pcif.pc_start) begin
            m_run = 1; m_adr = pcif.start_adr_lat; m_vid = 0; m_cnt = 0;
            m_pend.delete();
        end else if (!m_run) begin
            // idle: nothing moves
        end else if (pcif.rst_pipe) begin
            m_run = 0; m_vid = 0;
            m_pend.delete();
        end else if (!pcif.stall && (pcif.jmp_condition_ex || m_pend.size() != 0)) begin
            m_adr = pcif.jmp_condition_ex ? pcif.jmp_adr_ex : m_pend[0];
            m_fl = 1; m_vid = 0; m_cnt++;
            m_pend.delete();
        end else if (pcif.stall) begin
            if (pcif.jmp_condition_ex) begin
                m_pend.delete();
                m_pend.push_back(pcif.jmp_adr_ex);
            end
        end else begin
            m_id = m_adr; m_vid = 1; m_adr = m_adr + 30'd1; m_cnt++;
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);

        //           rst ps sa            st rp j  ja          e_adr         v  e_id          vid fl cnt
        tbl.push_back(mk(1, 0, 0,            0, 0, 0, 0,           30'h0,        0, 30'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 30'h55,      30'h0,        0, 30'h0,        0, 0, 0));
        tbl.push_back(mk(0, 1, 30'h100,      0, 0, 0, 0,           30'h100,      1, 30'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h101,      1, 30'h100,      1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h102,      1, 30'h101,      1, 0, 2));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h103,      1, 30'h102,      1, 0, 3));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h104,      1, 30'h103,      1, 0, 4));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,           30'h104,      1, 30'h103,      1, 0, 4));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,           30'h104,      1, 30'h103,      1, 0, 4));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,           30'h104,      1, 30'h103,      1, 0, 4));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h105,      1, 30'h104,      1, 0, 5));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 30'h200,     30'h105,      1, 30'h104,      1, 0, 5));
        tbl.push_back(mk(0, 0, 0,            1, 0, 0, 0,           30'h105,      1, 30'h104,      1, 0, 5));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h200,      1, 30'h104,      0, 1, 6));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h201,      1, 30'h200,      1, 0, 7));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 30'h300,     30'h300,      1, 30'h200,      0, 1, 8));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 30'h400,     30'h300,      1, 30'h200,      0, 0, 8));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 30'h500,     30'h300,      1, 30'h200,      0, 0, 8));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 30'h600,     30'h600,      1, 30'h200,      0, 1, 9));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 30'h700,     30'h600,      1, 30'h200,      0, 0, 9));
        tbl.push_back(mk(0, 1, 30'h40,       0, 1, 0, 0,           30'h40,       1, 30'h200,      0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h41,       1, 30'h40,       1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 1, 0, 0,           30'h41,       0, 30'h40,       0, 0, 1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 1, 30'h77,      30'h41,       0, 30'h40,       0, 0, 1));
        tbl.push_back(mk(0, 1, 30'h3FFFFFFF, 0, 0, 0, 0,           30'h3FFFFFFF, 1, 30'h40,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h0,        1, 30'h3FFFFFFF, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0,            1, 0, 1, 30'h123,     30'h0,        1, 30'h3FFFFFFF, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0,            1, 0, 0, 0,           30'h0,        0, 30'h0,        0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0,           30'h0,        0, 30'h0,        0, 0, 0));

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].ps, tbl[i].sa, tbl[i].st, tbl[i].rp, tbl[i].j, tbl[i].ja);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d if_adr", i),    64'(pcif.if_adr),         64'(tbl[i].e_adr));
            chk($sformatf("vec%0d if_valid", i),  64'(pcif.if_valid),       64'(tbl[i].e_v));
            chk($sformatf("vec%0d pc_id", i),     64'(pcif.pc_id),          64'(tbl[i].e_id));
            chk($sformatf("vec%0d pc_valid", i),  64'(pcif.pc_valid_if_id), 64'(tbl[i].e_vid));
            chk($sformatf("vec%0d jmp_flush", i), 64'(pcif.jmp_flush),      64'(tbl[i].e_fl));
            chk($sformatf("vec%0d fetch_cnt", i), 64'(pcif.fetch_cnt),      64'(cnt_exp(tbl[i].e_cnt)));
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_step();
        #1;

        for (int i = 0; i < 3000; i++) begin
            bit [29:0] sa;
            sa = ($urandom_range(0, 3) == 0) ? 30'(30'h3FFFFFF0 + $urandom_range(0, 15)) : 30'($urandom);
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 15) == 0,
                  sa,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 31) == 0,
                  $urandom_range(0, 5) == 0,
                  30'($urandom));
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("rnd%0d if_adr", i),    64'(pcif.if_adr),         64'(m_adr));
            chk($sformatf("rnd%0d if_valid", i),  64'(pcif.if_valid),       64'(m_run));
            chk($sformatf("rnd%0d pc_id", i),     64'(pcif.pc_id),          64'(m_id));
            chk($sformatf("rnd%0d pc_valid", i),  64'(pcif.pc_valid_if_id), 64'(m_vid));
            chk($sformatf("rnd%0d jmp_flush", i), 64'(pcif.jmp_flush),      64'(m_fl));
            chk($sformatf("rnd%0d fetch_cnt", i), 64'(pcif.fetch_cnt),      64'(cnt_exp(m_cnt)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
